// File: rtl/merge_pkg.sv
// Shared definitions for the index merge controller: FSM state encoding,
// default memory/index widths and the comparator result encoding.
package merge_pkg;

    // Default index/data memory address width (depth 2**AW) and index width
    localparam int unsigned AW_DEF = 4;
    localparam int unsigned DW_DEF = 8;

    // FSM state encoding
    localparam int unsigned SW = 3;
    localparam logic [SW-1:0] S_IDLE    = 3'd0;
    localparam logic [SW-1:0] S_FETCH   = 3'd1;
    localparam logic [SW-1:0] S_COMPARE = 3'd2;
    localparam logic [SW-1:0] S_EMIT    = 3'd3;
    localparam logic [SW-1:0] S_DONE    = 3'd4;

    // Comparator result: list-1 index relative to list-2 index
    localparam int unsigned CW = 2;
    localparam logic [CW-1:0] CMP_EQ = 2'b00;
    localparam logic [CW-1:0] CMP_LT = 2'b01;
    localparam logic [CW-1:0] CMP_GT = 2'b10;

endpackage : merge_pkg

// File: rtl/idx_comp.sv
// Combinational unsigned comparator for two index values.
// Ports:
//   i_a, i_b  : index values (list 1, list 2)
//   o_cmp_c   : CMP_LT / CMP_EQ / CMP_GT of i_a relative to i_b
module idx_comp
    import merge_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) (
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [CW-1:0] o_cmp_c
);

    always_comb begin
        o_cmp_c = CMP_EQ;
        if (i_a < i_b) begin
            o_cmp_c = CMP_LT;
        end else if (i_a > i_b) begin
            o_cmp_c = CMP_GT;
        end
    end

endmodule : idx_comp

// File: rtl/index_merge_ctrl.sv
// Sparse-vector intersection controller. Walks two ascending index lists
// held in synchronous-read memories and presents every equal-index position
// pair on a valid/ready handshake.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   start, len1, len2       : merge request and list lengths (sampled in IDLE)
//   idx_addr1/2, idx_data1/2: index memory read ports (1-cycle read latency)
//   match_valid/ready       : matched-pair handshake
//   match_addr1/2           : data memory addresses of the matched pair
//   busy, done, match_count : status
module index_merge_ctrl
    import merge_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW:0]   len1,
    input  logic [AW:0]   len2,
    output logic [AW-1:0] idx_addr1,
    output logic [AW-1:0] idx_addr2,
    input  logic [DW-1:0] idx_data1,
    input  logic [DW-1:0] idx_data2,
    output logic          match_valid,
    input  logic          match_ready,
    output logic [AW-1:0] match_addr1,
    output logic [AW-1:0] match_addr2,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   match_count
);

    localparam int unsigned   LW    = AW + 1;
    localparam logic [LW-1:0] DEPTH = LW'(2 ** AW);

    // State and datapath registers
    logic [SW-1:0] r_state;
    logic [LW-1:0] r_ptr1;
    logic [LW-1:0] r_ptr2;
    logic [LW-1:0] r_len1;
    logic [LW-1:0] r_len2;
    logic [LW-1:0] r_cnt;
    logic [AW-1:0] r_idx_addr1;
    logic [AW-1:0] r_idx_addr2;
    logic [AW-1:0] r_maddr1;
    logic [AW-1:0] r_maddr2;
    logic          r_mvalid;
    logic          r_busy;
    logic          r_done;

    // Next-state signals
    logic [SW-1:0] w_state_nxt;
    logic [LW-1:0] w_ptr1_nxt;
    logic [LW-1:0] w_ptr2_nxt;
    logic [LW-1:0] w_len1_nxt;
    logic [LW-1:0] w_len2_nxt;
    logic [LW-1:0] w_cnt_nxt;
    logic          w_latch_match;

    logic [LW-1:0] w_len1_sat;
    logic [LW-1:0] w_len2_sat;
    logic [LW-1:0] w_ptr1_inc;
    logic [LW-1:0] w_ptr2_inc;
    logic [CW-1:0] w_cmp_c;

    // Lengths beyond the memory depth clamp to the depth
    assign w_len1_sat = (len1 > DEPTH) ? DEPTH : len1;
    assign w_len2_sat = (len2 > DEPTH) ? DEPTH : len2;
    assign w_ptr1_inc = r_ptr1 + LW'(1);
    assign w_ptr2_inc = r_ptr2 + LW'(1);

    idx_comp #(
        .DW (DW)
    ) u_idx_comp (
        .i_a     (idx_data1),
        .i_b     (idx_data2),
        .o_cmp_c (w_cmp_c)
    );

    // Next-state and datapath update logic
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr1_nxt    = r_ptr1;
        w_ptr2_nxt    = r_ptr2;
        w_len1_nxt    = r_len1;
        w_len2_nxt    = r_len2;
        w_cnt_nxt     = r_cnt;
        w_latch_match = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_ptr1_nxt = '0;
                    w_ptr2_nxt = '0;
                    w_cnt_nxt  = '0;
                    w_len1_nxt = w_len1_sat;
                    w_len2_nxt = w_len2_sat;
                    if ((w_len1_sat != '0) && (w_len2_sat != '0)) begin
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end

            S_FETCH: begin
                w_state_nxt = S_COMPARE;
            end

            // Read data for the addresses issued in FETCH is valid here
            S_COMPARE: begin
                case (w_cmp_c)
                    CMP_LT: begin
                        w_ptr1_nxt  = w_ptr1_inc;
                        w_state_nxt = ((w_ptr1_inc == r_len1) || (r_ptr2 == r_len2))
                                      ? S_DONE : S_FETCH;
                    end
                    CMP_GT: begin
                        w_ptr2_nxt  = w_ptr2_inc;
                        w_state_nxt = ((r_ptr1 == r_len1) || (w_ptr2_inc == r_len2))
                                      ? S_DONE : S_FETCH;
                    end
                    default: begin
                        w_latch_match = 1'b1;
                        w_state_nxt   = S_EMIT;
                    end
                endcase
            end

            S_EMIT: begin
                if (match_ready) begin
                    w_ptr1_nxt  = w_ptr1_inc;
                    w_ptr2_nxt  = w_ptr2_inc;
                    w_cnt_nxt   = r_cnt + LW'(1);
                    w_state_nxt = ((w_ptr1_inc == r_len1) || (w_ptr2_inc == r_len2))
                                  ? S_DONE : S_FETCH;
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; outputs are registered from the next-state decode so
    // they line up with the state they describe
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ptr1      <= '0;
            r_ptr2      <= '0;
            r_len1      <= '0;
            r_len2      <= '0;
            r_cnt       <= '0;
            r_idx_addr1 <= '0;
            r_idx_addr2 <= '0;
            r_maddr1    <= '0;
            r_maddr2    <= '0;
            r_mvalid    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr1   <= w_ptr1_nxt;
            r_ptr2   <= w_ptr2_nxt;
            r_len1   <= w_len1_nxt;
            r_len2   <= w_len2_nxt;
            r_cnt    <= w_cnt_nxt;
            r_mvalid <= (w_state_nxt == S_EMIT);
            r_busy   <= (w_state_nxt != S_IDLE);
            r_done   <= (w_state_nxt == S_DONE);
            // Addresses change only on entry to FETCH and hold through COMPARE
            if (w_state_nxt == S_FETCH) begin
                r_idx_addr1 <= w_ptr1_nxt[AW-1:0];
                r_idx_addr2 <= w_ptr2_nxt[AW-1:0];
            end
            if (w_latch_match) begin
                r_maddr1 <= r_ptr1[AW-1:0];
                r_maddr2 <= r_ptr2[AW-1:0];
            end
        end
    end

    assign idx_addr1   = r_idx_addr1;
    assign idx_addr2   = r_idx_addr2;
    assign match_valid = r_mvalid;
    assign match_addr1 = r_maddr1;
    assign match_addr2 = r_maddr2;
    assign busy        = r_busy;
    assign done        = r_done;
    assign match_count = r_cnt;

endmodule : index_merge_ctrl

// File: tb/tb_index_merge_ctrl.sv
// Directed, table-driven bench for index_merge_ctrl with synchronous-read
// index memory models.
module tb_index_merge_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   len1;
    logic [AW:0]   len2;
    logic [AW-1:0] idx_addr1;
    logic [AW-1:0] idx_addr2;
    logic [DW-1:0] idx_data1;
    logic [DW-1:0] idx_data2;
    logic          match_valid;
    logic          match_ready;
    logic [AW-1:0] match_addr1;
    logic [AW-1:0] match_addr2;
    logic          busy;
    logic          done;
    logic [AW:0]   match_count;

    always #5 clk = ~clk;

    index_merge_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .len1        (len1),
        .len2        (len2),
        .idx_addr1   (idx_addr1),
        .idx_addr2   (idx_addr2),
        .idx_data1   (idx_data1),
        .idx_data2   (idx_data2),
        .match_valid (match_valid),
        .match_ready (match_ready),
        .match_addr1 (match_addr1),
        .match_addr2 (match_addr2),
        .busy        (busy),
        .done        (done),
        .match_count (match_count)
    );

    // Index memories: one-cycle synchronous read
    logic [DW-1:0] mem1 [16];
    logic [DW-1:0] mem2 [16];
    always_ff @(posedge clk) begin
        idx_data1 <= mem1[idx_addr1];
        idx_data2 <= mem2[idx_addr2];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int len1;
        int len2;
        int l1 [16];
        int l2 [16];
        int stall;      // ready-low cycles before each accept
        bit second;     // pulse a second start while busy
        int n;          // expected pair count
        int a1 [16];
        int a2 [16];
        int done_cyc;   // expected cycle of done after start, -1 = unchecked
    } vec_t;

    localparam int NV = 6;
    vec_t vt [NV];

    task automatic clear_vec(input int v);
        vt[v].len1 = 0; vt[v].len2 = 0; vt[v].stall = 0; vt[v].second = 1'b0;
        vt[v].n = 0; vt[v].done_cyc = -1;
        for (int k = 0; k < 16; k++) begin
            vt[v].l1[k] = 0; vt[v].l2[k] = 0; vt[v].a1[k] = 0; vt[v].a2[k] = 0;
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_idx_addr1"},   int'(idx_addr1), 0);
        chk({tag, "_idx_addr2"},   int'(idx_addr2), 0);
        chk({tag, "_match_valid"}, int'(match_valid), 0);
        chk({tag, "_match_addr1"}, int'(match_addr1), 0);
        chk({tag, "_match_addr2"}, int'(match_addr2), 0);
        chk({tag, "_busy"},        int'(busy), 0);
        chk({tag, "_done"},        int'(done), 0);
        chk({tag, "_match_count"}, int'(match_count), 0);
    endtask

    task automatic load_mem(input int v);
        for (int k = 0; k < 16; k++) begin
            mem1[k] = 8'(vt[v].l1[k]);
            mem2[k] = 8'(vt[v].l2[k]);
        end
    endtask

    task automatic run_vec(input int v);
        logic [AW-1:0] a0, b0, h1, h2;
        int  npairs, done_at, done_hi, valid_cnt, waited;
        bit  hold, addr_moved;
        string nm;
        nm = $sformatf("v%0d", v);
        load_mem(v);
        match_ready = 1'b0;
        a0 = idx_addr1; b0 = idx_addr2;
        npairs = 0; done_at = -1; done_hi = 0; valid_cnt = 0; waited = 0;
        hold = 1'b0; addr_moved = 1'b0; h1 = '0; h2 = '0;
        @(negedge clk);
        start = 1'b1;
        len1  = 5'(vt[v].len1);
        len2  = 5'(vt[v].len2);
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (vt[v].second && cyc == 3) begin
                start = 1'b1;
                len1  = 5'd0;
            end
            if (vt[v].second && cyc == 4) start = 1'b0;
            if (idx_addr1 !== a0 || idx_addr2 !== b0) addr_moved = 1'b1;
            if (done) begin
                done_hi++;
                if (done_at < 0) done_at = cyc;
            end
            if (match_valid) begin
                valid_cnt++;
                if (!hold) begin
                    hold = 1'b1; h1 = match_addr1; h2 = match_addr2;
                end else begin
                    chk({nm, "_stall_addr1"}, int'(match_addr1), int'(h1));
                    chk({nm, "_stall_addr2"}, int'(match_addr2), int'(h2));
                end
                if (waited >= vt[v].stall) begin
                    // Accepted on the coming rising edge
                    match_ready = 1'b1;
                    if (npairs < 16) begin
                        chk({nm, "_pair_addr1"}, int'(match_addr1), vt[v].a1[npairs]);
                        chk({nm, "_pair_addr2"}, int'(match_addr2), vt[v].a2[npairs]);
                    end
                    npairs++;
                    hold = 1'b0;
                    waited = 0;
                end else begin
                    match_ready = 1'b0;
                    waited++;
                end
            end else begin
                match_ready = (vt[v].stall == 0);
            end
            if (done_at >= 0 && cyc >= done_at + 2) break;
        end
        match_ready = 1'b0;
        chk({nm, "_done_seen"}, int'(done_at >= 0), 1);
        if (vt[v].done_cyc >= 0) chk({nm, "_done_cycle"}, done_at, vt[v].done_cyc);
        chk({nm, "_done_pulses"}, done_hi, 1);
        chk({nm, "_busy_after"}, int'(busy), 0);
        chk({nm, "_pairs"}, npairs, vt[v].n);
        chk({nm, "_match_count"}, int'(match_count), vt[v].n);
        if (vt[v].n == 0) chk({nm, "_valid_cycles"}, valid_cnt, 0);
        if (vt[v].len1 == 0 || vt[v].len2 == 0) chk({nm, "_addr_moved"}, int'(addr_moved), 0);
    endtask

    initial begin
        bit seen;
        for (int v = 0; v < NV; v++) clear_vec(v);

        // Overlapping lists, ready always high
        vt[0].len1 = 4; vt[0].len2 = 4;
        vt[0].l1[0] = 1; vt[0].l1[1] = 3; vt[0].l1[2] = 5; vt[0].l1[3] = 7;
        vt[0].l2[0] = 3; vt[0].l2[1] = 4; vt[0].l2[2] = 7; vt[0].l2[3] = 9;
        vt[0].n = 2;
        vt[0].a1[0] = 1; vt[0].a2[0] = 0;
        vt[0].a1[1] = 3; vt[0].a2[1] = 2;
        vt[0].done_cyc = 13;
        // Disjoint lists
        vt[1].len1 = 3; vt[1].len2 = 3;
        vt[1].l1[0] = 0; vt[1].l1[1] = 2; vt[1].l1[2] = 4;
        vt[1].l2[0] = 1; vt[1].l2[1] = 3; vt[1].l2[2] = 5;
        vt[1].done_cyc = 11;
        // Identical full lists, consumer stalls 3 cycles per pair
        vt[2].len1 = 16; vt[2].len2 = 16; vt[2].stall = 3; vt[2].n = 16;
        // Zero-length list 1
        vt[3].len1 = 0; vt[3].len2 = 5; vt[3].done_cyc = 1;
        for (int k = 0; k < 5; k++) vt[3].l2[k] = k;
        // Oversized lengths saturate to 16
        vt[4].len1 = 20; vt[4].len2 = 31; vt[4].n = 16;
        for (int k = 0; k < 16; k++) begin
            vt[2].l1[k] = k; vt[2].l2[k] = k; vt[2].a1[k] = k; vt[2].a2[k] = k;
            vt[4].l1[k] = k; vt[4].l2[k] = k; vt[4].a1[k] = k; vt[4].a2[k] = k;
        end
        // Same as vector 0 with a second start while busy
        vt[5] = vt[0];
        vt[5].second = 1'b1;

        for (int k = 0; k < 16; k++) begin
            mem1[k] = '0; mem2[k] = '0;
        end
        reset = 1'b1; start = 1'b0; len1 = '0; len2 = '0; match_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        reset = 1'b0;

        for (int v = 0; v < NV; v++) run_vec(v);

        // Reset while a pair is pending in EMIT
        load_mem(0);
        match_ready = 1'b0;
        @(negedge clk);
        start = 1'b1; len1 = 5'd4; len2 = 5'd4;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (match_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("emit_reached", int'(seen), 1);
        start = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outs("midreset");
        start = 1'b0;
        reset = 1'b0;
        run_vec(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_index_merge_ctrl
